// File: rtl/ledger_validator_if.sv
// Transaction in/out handshake bundle for ledger_validator.
// slave = the validator, master = the upstream/downstream driver.
interface ledger_validator_if #(
   parameter int ID_W  = 48,
   parameter int AMT_W = 22
);
   localparam int DW = 2*ID_W + AMT_W + 1;

   logic [DW-1:0] data_i;
   logic          valid_i;
   logic          ready_o;
   logic [DW-1:0] data_o;
   logic [2:0]    status_o;
   logic          valid_o;
   logic          ready_i;

   modport slave  (input data_i, valid_i, ready_i, output ready_o, data_o, status_o, valid_o);
   modport master (output data_i, valid_i, ready_i, input ready_o, data_o, status_o, valid_o);
endinterface

// File: rtl/ledger_validator.sv
// Account-table transfer validator: scans for sender/receiver, allocates missing
// accounts, checks funds/overflow and applies the transfer. LEDGER_STATS_EN adds counters.
module ledger_validator #(
   parameter int ID_W     = 48,
   parameter int AMT_W    = 22,
   parameter int BAL_W    = 24,
   parameter int DEPTH    = 16384,
   parameter int INIT_BAL = 100
) (
   input  logic clk,
   input  logic rst_n,
   ledger_validator_if.slave bus
`ifdef LEDGER_STATS_EN
   ,
   output logic [31:0] acc_cnt_o,
   output logic [31:0] rej_cnt_o
`endif
);
   localparam int DW = 2*ID_W + AMT_W + 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [BAL_W-1:0] INIT_V = BAL_W'(INIT_BAL);
   localparam logic [CW:0] TWO = 2;

   typedef enum logic [2:0] {IDLE, SCAN, ALLOC, CHECK, WR_SND, WR_RCV, OUT} state_t;
   state_t state_reg, state_next;

   logic [DW-1:0]    txn_reg;
   logic [2:0]       status_reg;
   logic [CW-1:0]    count_reg, scan_ptr_reg, chk_ptr_reg;
   logic             chk_valid_reg, run_reg;
   logic             snd_found_reg, rcv_found_reg;
   logic [AW-1:0]    snd_idx_reg, rcv_idx_reg;
   logic [BAL_W-1:0] snd_bal_reg, rcv_bal_reg;

   logic [ID_W-1:0]  id_mem  [DEPTH];
   logic [BAL_W-1:0] bal_mem [DEPTH];

   logic [ID_W-1:0]  snd_id, rcv_id, in_snd, in_rcv;
   logic [AMT_W-1:0] amt;
   logic [BAL_W-1:0] amt_ext;
   logic [BAL_W:0]   rcv_sum;
   logic [2:0]       chk_status;
   logic             accept, scan_done, alloc_full;
   logic [1:0]       need, hit_s, hit_r;
   logic [1:0][BAL_W-1:0] rd_bal;
   logic [CW-1:0]    free_cnt;
   logic [CW:0]      chk_end;

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [ID_W-1:0]  wr_id;
   logic [BAL_W-1:0] wr_bal;

   assign snd_id  = txn_reg[DW-1 -: ID_W];
   assign rcv_id  = txn_reg[AMT_W+1 +: ID_W];
   assign amt     = txn_reg[1 +: AMT_W];
   assign in_snd  = bus.data_i[DW-1 -: ID_W];
   assign in_rcv  = bus.data_i[AMT_W+1 +: ID_W];
   assign accept  = (state_reg == IDLE) && run_reg && bus.valid_i;
   assign amt_ext = BAL_W'(amt);
   assign rcv_sum = {1'b0, rcv_bal_reg} + {1'b0, amt_ext};
   assign chk_status = (snd_bal_reg < amt_ext) ? 3'd1 : (rcv_sum[BAL_W] ? 3'd3 : 3'd0);

   // Two read ports walk the table in pairs; data lags the address by one cycle.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [AW-1:0]    raddr;
      logic [ID_W-1:0]  rd_id_q;
      logic [BAL_W-1:0] rd_bal_q;
      assign raddr = scan_ptr_reg[AW-1:0] + AW'(gi);
      always_ff @(posedge clk) begin
         rd_id_q  <= id_mem[raddr];
         rd_bal_q <= bal_mem[raddr];
      end
      assign rd_bal[gi] = rd_bal_q;
      assign hit_s[gi]  = chk_valid_reg && ((chk_ptr_reg + CW'(gi)) < count_reg) && (rd_id_q == snd_id);
      assign hit_r[gi]  = chk_valid_reg && ((chk_ptr_reg + CW'(gi)) < count_reg) && (rd_id_q == rcv_id);
   end

   assign chk_end   = {1'b0, chk_ptr_reg} + TWO;
   assign scan_done = ((snd_found_reg || (|hit_s)) && (rcv_found_reg || (|hit_r))) ||
                      (chk_valid_reg ? (chk_end >= {1'b0, count_reg}) : (count_reg == '0));

   assign need       = {1'b0, ~snd_found_reg} + {1'b0, ~rcv_found_reg};
   assign free_cnt   = CW'(DEPTH) - count_reg;
   assign alloc_full = free_cnt < {{(CW-2){1'b0}}, need};

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = count_reg[AW-1:0];
      wr_id   = snd_id;
      wr_bal  = INIT_V;
      unique case (state_reg)
         ALLOC: begin
            wr_en = !alloc_full && (need != 2'd0);
            wr_id = snd_found_reg ? rcv_id : snd_id;
         end
         WR_SND: begin
            wr_en   = 1'b1;
            wr_addr = snd_idx_reg;
            wr_bal  = snd_bal_reg - amt_ext;
         end
         WR_RCV: begin
            wr_en   = 1'b1;
            wr_addr = rcv_idx_reg;
            wr_id   = rcv_id;
            wr_bal  = rcv_bal_reg + amt_ext;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         id_mem[wr_addr]  <= wr_id;
         bal_mem[wr_addr] <= wr_bal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (accept) state_next = (in_snd == in_rcv) ? OUT : SCAN;
         SCAN:    if (scan_done) state_next = ALLOC;
         ALLOC:   if (alloc_full) state_next = OUT;
                  else if (need <= 2'd1) state_next = CHECK;
         CHECK:   state_next = (chk_status == 3'd0) ? WR_SND : OUT;
         WR_SND:  state_next = WR_RCV;
         WR_RCV:  state_next = OUT;
         OUT:     if (bus.ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.ready_o  = run_reg && (state_reg == IDLE);
      bus.valid_o  = (state_reg == OUT);
      bus.data_o   = txn_reg;
      bus.status_o = status_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_reg       <= 1'b0;
         txn_reg       <= '0;
         status_reg    <= '0;
         count_reg     <= '0;
         scan_ptr_reg  <= '0;
         chk_ptr_reg   <= '0;
         chk_valid_reg <= 1'b0;
         snd_found_reg <= 1'b0;
         rcv_found_reg <= 1'b0;
         snd_idx_reg   <= '0;
         rcv_idx_reg   <= '0;
         snd_bal_reg   <= '0;
         rcv_bal_reg   <= '0;
      end else begin
         run_reg <= 1'b1;
         unique case (state_reg)
            IDLE: if (accept) begin
               txn_reg       <= bus.data_i;
               status_reg    <= (in_snd == in_rcv) ? 3'd4 : 3'd0;
               scan_ptr_reg  <= '0;
               chk_valid_reg <= 1'b0;
               snd_found_reg <= 1'b0;
               rcv_found_reg <= 1'b0;
               if (bus.data_i[0]) count_reg <= '0;
            end
            SCAN: begin
               chk_valid_reg <= 1'b1;
               chk_ptr_reg   <= scan_ptr_reg;
               scan_ptr_reg  <= scan_ptr_reg + CW'(2);
               if (hit_s[0]) begin
                  snd_found_reg <= 1'b1;
                  snd_idx_reg   <= chk_ptr_reg[AW-1:0];
                  snd_bal_reg   <= rd_bal[0];
               end else if (hit_s[1]) begin
                  snd_found_reg <= 1'b1;
                  snd_idx_reg   <= chk_ptr_reg[AW-1:0] + AW'(1);
                  snd_bal_reg   <= rd_bal[1];
               end
               if (hit_r[0]) begin
                  rcv_found_reg <= 1'b1;
                  rcv_idx_reg   <= chk_ptr_reg[AW-1:0];
                  rcv_bal_reg   <= rd_bal[0];
               end else if (hit_r[1]) begin
                  rcv_found_reg <= 1'b1;
                  rcv_idx_reg   <= chk_ptr_reg[AW-1:0] + AW'(1);
                  rcv_bal_reg   <= rd_bal[1];
               end
            end
            // One account per cycle; sender always takes the lower index.
            ALLOC: begin
               if (alloc_full) begin
                  status_reg <= 3'd2;
               end else if (need != 2'd0) begin
                  count_reg <= count_reg + CW'(1);
                  if (!snd_found_reg) begin
                     snd_found_reg <= 1'b1;
                     snd_idx_reg   <= count_reg[AW-1:0];
                     snd_bal_reg   <= INIT_V;
                  end else begin
                     rcv_found_reg <= 1'b1;
                     rcv_idx_reg   <= count_reg[AW-1:0];
                     rcv_bal_reg   <= INIT_V;
                  end
               end
            end
            CHECK: status_reg <= chk_status;
            default: ;
         endcase
      end
   end

`ifdef LEDGER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt_o <= '0;
         rej_cnt_o <= '0;
      end else if (state_reg == OUT && bus.ready_i) begin
         if (status_reg == 3'd0) acc_cnt_o <= acc_cnt_o + 32'd1;
         else                    rej_cnt_o <= rej_cnt_o + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ledger_validator.sv
// Directed bench for ledger_validator: default table, a 4-entry table and an
// 8-bit balance table, plus reset behaviour while a result is held.
module tb_ledger_validator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   ledger_validator_if #(.ID_W(48), .AMT_W(22)) if_a();
   ledger_validator_if #(.ID_W(48), .AMT_W(22)) if_d();
   ledger_validator_if #(.ID_W(48), .AMT_W(8))  if_s();

`ifdef LEDGER_STATS_EN
   logic [31:0] acc_a, rej_a, acc_d, rej_d, acc_s, rej_s;
`endif

   ledger_validator #(.ID_W(48), .AMT_W(22), .BAL_W(24), .DEPTH(16384), .INIT_BAL(100)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a)
`ifdef LEDGER_STATS_EN
      , .acc_cnt_o(acc_a), .rej_cnt_o(rej_a)
`endif
   );
   ledger_validator #(.ID_W(48), .AMT_W(22), .BAL_W(24), .DEPTH(4), .INIT_BAL(100)) u_d (
      .clk(clk), .rst_n(rst_n), .bus(if_d)
`ifdef LEDGER_STATS_EN
      , .acc_cnt_o(acc_d), .rej_cnt_o(rej_d)
`endif
   );
   ledger_validator #(.ID_W(48), .AMT_W(8), .BAL_W(8), .DEPTH(16), .INIT_BAL(250)) u_s (
      .clk(clk), .rst_n(rst_n), .bus(if_s)
`ifdef LEDGER_STATS_EN
      , .acc_cnt_o(acc_s), .rej_cnt_o(rej_s)
`endif
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input int inst, input logic [47:0] snd, input logic [47:0] rcv,
                         input logic [21:0] amt, input logic bs, input logic v);
      case (inst)
         0: begin if_a.data_i = {snd, rcv, amt, bs}; if_a.valid_i = v; end
         1: begin if_d.data_i = {snd, rcv, amt, bs}; if_d.valid_i = v; end
         default: begin if_s.data_i = {snd, rcv, amt[7:0], bs}; if_s.valid_i = v; end
      endcase
   endtask

   task automatic set_valid(input int inst, input logic v);
      case (inst)
         0: if_a.valid_i = v;
         1: if_d.valid_i = v;
         default: if_s.valid_i = v;
      endcase
   endtask

   task automatic set_rdy(input int inst, input logic r);
      case (inst)
         0: if_a.ready_i = r;
         1: if_d.ready_i = r;
         default: if_s.ready_i = r;
      endcase
   endtask

   function automatic logic get_ready(input int inst);
      case (inst)
         0: return if_a.ready_o;
         1: return if_d.ready_o;
         default: return if_s.ready_o;
      endcase
   endfunction

   function automatic logic get_valid(input int inst);
      case (inst)
         0: return if_a.valid_o;
         1: return if_d.valid_o;
         default: return if_s.valid_o;
      endcase
   endfunction

   function automatic logic [2:0] get_status(input int inst);
      case (inst)
         0: return if_a.status_o;
         1: return if_d.status_o;
         default: return if_s.status_o;
      endcase
   endfunction

   function automatic logic [118:0] get_data(input int inst);
      case (inst)
         0: return if_a.data_o;
         1: return if_d.data_o;
         default: return {14'b0, if_s.data_o};
      endcase
   endfunction

   // Send one transaction, wait for the result, complete the output handshake.
   task automatic txn(input string tag, input int inst, input logic [47:0] snd, input logic [47:0] rcv,
                      input logic [21:0] amt, input logic bs, input logic [2:0] exp_st, output int lat);
      logic [118:0] exp_d;
      int w;
      exp_d = (inst == 2) ? {14'b0, snd, rcv, amt[7:0], bs} : {snd, rcv, amt, bs};
      @(negedge clk);
      set_in(inst, snd, rcv, amt, bs, 1'b1);
      w = 0;
      while (!get_ready(inst) && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({tag, " ready"}, get_ready(inst), 1'b1);
      @(negedge clk);
      set_valid(inst, 1'b0);
      lat = 1;
      while (!get_valid(inst) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " valid"}, get_valid(inst), 1'b1);
      check({tag, " status"}, get_status(inst), exp_st);
      check({tag, " data"}, get_data(inst), exp_d);
      $display("txn %s inst=%0d status=%0d expected=%0d latency=%0d", tag, inst, get_status(inst), exp_st, lat);
      set_rdy(inst, 1'b1);
      @(negedge clk);
      set_rdy(inst, 1'b0);
      check({tag, " valid drop"}, get_valid(inst), 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      logic [118:0] held;
      if_a.data_i = '0; if_a.valid_i = 1'b0; if_a.ready_i = 1'b0;
      if_d.data_i = '0; if_d.valid_i = 1'b0; if_d.ready_i = 1'b0;
      if_s.data_i = '0; if_s.valid_i = 1'b0; if_s.ready_i = 1'b0;

      @(negedge clk);
      check("rst ready", if_a.ready_o, 1'b0);
      check("rst valid", if_a.valid_o, 1'b0);
      check("rst data", if_a.data_o, 0);
      check("rst status", if_a.status_o, 0);
      rst_n = 1'b1;
      #1;
      check("ready before edge", if_a.ready_o, 1'b0);
      @(negedge clk);
      check("ready after edge", if_a.ready_o, 1'b1);

      txn("A>B 30 new", 0, 48'd1, 48'd2, 22'd30, 1'b1, 3'd0, lat);
      check("count after first", u_a.count_reg, 2);
      txn("A>B 71 nsf", 0, 48'd1, 48'd2, 22'd71, 1'b0, 3'd1, lat);
      check("count after nsf", u_a.count_reg, 2);
      txn("A>A 5 self", 0, 48'd1, 48'd1, 22'd5, 1'b0, 3'd4, lat);
      check("self latency<=2", (lat <= 2), 1'b1);
      check("count after self", u_a.count_reg, 2);
      txn("A>B 70 exact", 0, 48'd1, 48'd2, 22'd70, 1'b0, 3'd0, lat);
      txn("B>A 201 nsf", 0, 48'd2, 48'd1, 22'd201, 1'b0, 3'd1, lat);
      txn("B>A 200 exact", 0, 48'd2, 48'd1, 22'd200, 1'b0, 3'd0, lat);
      txn("A>C 1 newrcv", 0, 48'd1, 48'd3, 22'd1, 1'b0, 3'd0, lat);
      check("count 3", u_a.count_reg, 3);
      txn("D>E 1 both new", 0, 48'd4, 48'd5, 22'd1, 1'b0, 3'd0, lat);
      check("count 5", u_a.count_reg, 5);
      txn("E>D 101 exact", 0, 48'd5, 48'd4, 22'd101, 1'b0, 3'd0, lat);
      txn("E>D 1 empty", 0, 48'd5, 48'd4, 22'd1, 1'b0, 3'd1, lat);
      txn("A>B 1 blkstart", 0, 48'd1, 48'd2, 22'd1, 1'b1, 3'd0, lat);
      check("count blkstart", u_a.count_reg, 2);
`ifdef LEDGER_STATS_EN
      check("acc count", acc_a, 32'd7);
      check("rej count", rej_a, 32'd4);
`endif

      txn("d P>Q", 1, 48'd10, 48'd11, 22'd1, 1'b1, 3'd0, lat);
      txn("d R>P", 1, 48'd12, 48'd10, 22'd1, 1'b0, 3'd0, lat);
      check("d count 3", u_d.count_reg, 3);
      txn("d S>T full", 1, 48'd13, 48'd14, 22'd1, 1'b0, 3'd2, lat);
      check("d count still 3", u_d.count_reg, 3);
      txn("d S>P", 1, 48'd13, 48'd10, 22'd1, 1'b0, 3'd0, lat);
      check("d count 4", u_d.count_reg, 4);
      txn("d C>E full", 1, 48'd15, 48'd16, 22'd1, 1'b0, 3'd2, lat);
      check("d count stays 4", u_d.count_reg, 4);
      txn("d Q>S known", 1, 48'd11, 48'd13, 22'd1, 1'b0, 3'd0, lat);
      txn("d P>C full", 1, 48'd10, 48'd15, 22'd1, 1'b0, 3'd2, lat);

      txn("s X>Y 10 ovf", 2, 48'd20, 48'd21, 22'd10, 1'b1, 3'd3, lat);
      txn("s X>Y 5 max", 2, 48'd20, 48'd21, 22'd5, 1'b0, 3'd0, lat);
      txn("s Y>X 255 ovf", 2, 48'd21, 48'd20, 22'd255, 1'b0, 3'd3, lat);
      txn("s X>Y 251 both", 2, 48'd20, 48'd21, 22'd251, 1'b0, 3'd1, lat);

      // Hold a result at OUT, then reset underneath it.
      @(negedge clk);
      set_in(0, 48'd1, 48'd2, 22'd1, 1'b0, 1'b1);
      @(negedge clk);
      set_valid(0, 1'b0);
      lat = 1;
      while (!if_a.valid_o && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("hold valid", if_a.valid_o, 1'b1);
      held = if_a.data_o;
      check("hold data", held, {48'd1, 48'd2, 22'd1, 1'b0});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold valid stable", if_a.valid_o, 1'b1);
         check("hold data stable", if_a.data_o, held);
         check("hold status", if_a.status_o, 3'd0);
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid rst valid", if_a.valid_o, 1'b0);
      check("mid rst ready", if_a.ready_o, 1'b0);
      check("mid rst data", if_a.data_o, 0);
      check("mid rst status", if_a.status_o, 0);
      check("mid rst count", u_a.count_reg, 0);
`ifdef LEDGER_STATS_EN
      check("mid rst acc", acc_a, 32'd0);
      check("mid rst rej", rej_a, 32'd0);
`endif
      $display("txn reset-abort inst=0 valid=%0d", if_a.valid_o);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready after rst", if_a.ready_o, 1'b1);
      txn("A>B 30 post rst", 0, 48'd1, 48'd2, 22'd30, 1'b0, 3'd0, lat);
      check("count post rst", u_a.count_reg, 2);
      txn("A>B 71 post rst", 0, 48'd1, 48'd2, 22'd71, 1'b0, 3'd1, lat);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/ledger_validator.md
LEDGER_VALIDATOR -- requirements
Module: ledger_validator

Interface
REQ-001 SHALL have parameter ID_W, default 48, account identifier width.
REQ-002 SHALL have parameter AMT_W, default 22, transfer amount width.
REQ-003 SHALL have parameter BAL_W, default 24, stored balance width; BAL_W >= AMT_W.
REQ-004 SHALL have parameter DEPTH, default 16384, account table entries; power of two, >= 4.
REQ-005 SHALL have parameter INIT_BAL, default 100, opening balance of a newly allocated account.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-008 SHALL have port data_i  input  2*ID_W+AMT_W+1  transaction {sender, receiver, amount, block_start}.
REQ-009 SHALL have port valid_i  input  1  data_i valid.
REQ-010 SHALL have port ready_o  output  1  block accepts data_i.
REQ-011 SHALL have port data_o  output  2*ID_W+AMT_W+1  the processed transaction, unmodified.
REQ-012 SHALL have port status_o  output  3  result: 0 OK, 1 insufficient funds, 2 table full, 3 receiver overflow, 4 self-transfer.
REQ-013 SHALL have port valid_o  output  1  data_o/status_o valid.
REQ-014 SHALL have port ready_i  input  1  downstream accepts the result.

Function
REQ-015 SHALL accept a transaction on a cycle where valid_i && ready_o; ready_o SHALL be 1 only in state IDLE.
REQ-016 SHALL use states IDLE, SCAN, ALLOC, CHECK, WR_SND, WR_RCV, OUT.
REQ-017 IDLE->SCAN on accept; block_start=1 SHALL clear the allocated-entry count to 0 before the scan, so the scan finds no accounts.
REQ-018 SCAN SHALL compare two table entries per cycle (two read ports, one-cycle read latency) against sender and receiver.
REQ-019 SCAN SHALL stop on whichever comes first: both accounts found, or all allocated entries examined.
REQ-020 SCAN SHALL ignore entries at index >= allocated count.
REQ-021 Scan latency SHALL be at most ceil(count/2)+2 cycles.
REQ-022 sender==receiver SHALL skip SCAN/ALLOC/CHECK/writes and go to OUT with status 4.
REQ-023 ALLOC SHALL give each missing account the next free index at INIT_BAL; sender allocated before receiver.
REQ-024 If fewer free entries exist than needed, ALLOC SHALL allocate nothing and go to OUT with status 2.
REQ-025 CHECK SHALL set status 1 if sender balance < amount.
REQ-026 CHECK SHALL set status 3 if receiver balance + amount > 2^BAL_W-1, evaluated at BAL_W+1 bits.
REQ-027 When status 1 and 3 both hold, status SHALL be 1.
REQ-028 CHECK with status 0 SHALL go to WR_SND (write sender - amount), then WR_RCV (write receiver + amount), then OUT.
REQ-029 CHECK with nonzero status SHALL go directly to OUT.
REQ-030 On rejection, accounts allocated in ALLOC SHALL remain in the table at INIT_BAL.
REQ-031 OUT SHALL hold valid_o=1 with data_o and status_o stable until ready_i=1, then return to IDLE.
REQ-032 Table writes SHALL be visible to the next transaction's scan.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, ready_o=0, valid_o=0, data_o=0, status_o=0 and allocated count=0.
REQ-034 Table contents SHALL NOT be cleared by reset; they are unreachable because count=0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no output produced.
REQ-036 ready_o SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-037 With LEDGER_STATS_EN defined, SHALL add 32-bit outputs acc_cnt_o and rej_cnt_o, reset to 0, incremented on each OUT handshake with status 0 and with status nonzero respectively, wrapping at 2^32.
REQ-038 Without LEDGER_STATS_EN, those ports and counters SHALL NOT exist.

Verification
REQ-039 Block_start, A->B amount 30 -> status 0; A=70, B=130; count=2.
REQ-040 Then A->B amount 71 -> status 1; no table write; count unchanged.
REQ-041 A->A amount 5 -> status 4; no table write; output within 2 cycles of accept.
REQ-042 DEPTH=4: fill 4 accounts, then C->E amount 1 with C new -> status 2; count stays 4.
REQ-043 BAL_W=8, AMT_W=8, INIT_BAL=250: X->Y amount 10 -> status 3.
REQ-044 Hold ready_i=0 for 5 cycles at OUT, then assert rst_n=0 -> valid_o stays stable before reset and falls immediately on reset; acc_cnt_o=0 when LEDGER_STATS_EN is defined.
